// File: rtl/regfile_write_initiator.sv
// Write-port initiator between execute/writeback and the register file:
// holds one result as a level request until the register file's flush pulse.
module regfile_write_initiator #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_reg_write,
    input  logic [4:0]         i_rd,
    input  logic [31:0]        i_result,
    output logic [4:0]         o_rd,
    output logic [31:0]        o_write_data,
    output logic               o_data_ready,
    input  logic               i_flush,
    output logic               o_done,
    output logic               o_timeout,
    output logic [COUNT_W-1:0] o_retire_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [TW-1:0] tcount;

    assign o_ready = (state == IDLE);

    // o_done and the retire count are updated on the transition into DONE so
    // the pulse and the new count are both visible during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tcount         <= '0;
            o_rd           <= '0;
            o_write_data   <= '0;
            o_data_ready   <= 1'b0;
            o_done         <= 1'b0;
            o_timeout      <= 1'b0;
            o_retire_count <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_rd         <= i_rd;
                        o_write_data <= i_result;
                        if (i_reg_write && (i_rd != 5'd0)) begin
                            state        <= REQ;
                            o_data_ready <= 1'b1;
                            tcount       <= '0;
                        end else begin
                            state          <= DONE;
                            o_done         <= 1'b1;
                            o_retire_count <= o_retire_count + COUNT_W'(1);
                        end
                    end
                end
                REQ: begin
                    if (i_flush) begin
                        o_data_ready <= 1'b0;
                        state        <= RELEASE;
                    end else if (tcount == T_LAST) begin
                        o_data_ready <= 1'b0;
                        o_timeout    <= 1'b1;
                        state        <= RELEASE;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
                end
                // Request is low here, so the next request is a fresh rising edge.
                RELEASE: begin
                    if (!i_flush) begin
                        state          <= DONE;
                        o_done         <= 1'b1;
                        o_retire_count <= o_retire_count + COUNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_initiator.sv
// Directed bench for regfile_write_initiator with a behavioural register file
// that returns a one-cycle flush five cycles after each request rises.
module tb_regfile_write_initiator;

    localparam int TIMEOUT_CYCLES = 8;
    localparam int COUNT_W        = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_reg_write = 1'b0;
    logic [4:0]         i_rd = 5'd0;
    logic [31:0]        i_result = 32'd0;
    logic               i_flush;
    logic               o_ready;
    logic [4:0]         o_rd;
    logic [31:0]        o_write_data;
    logic               o_data_ready;
    logic               o_done;
    logic               o_timeout;
    logic [COUNT_W-1:0] o_retire_count;

    int checks = 0;
    int fails  = 0;
    logic [COUNT_W-1:0] exp_count = '0;

    regfile_write_initiator #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_reg_write(i_reg_write), .i_rd(i_rd), .i_result(i_result),
        .o_rd(o_rd), .o_write_data(o_write_data), .o_data_ready(o_data_ready),
        .i_flush(i_flush), .o_done(o_done), .o_timeout(o_timeout),
        .o_retire_count(o_retire_count)
    );

    always #5 clk = ~clk;

    // Register file model: request rise seen at edge R, write at R+4, flush high for the cycle after.
    logic [31:0] rf_mem [32];
    logic        rf_loaded = 1'b0;
    logic        rf_prev;
    int          rf_cnt;
    logic        rf_enable = 1'b1;
    int          rf_req_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_prev <= 1'b0;
            rf_cnt  <= 0;
            i_flush <= 1'b0;
        end else begin
            rf_prev <= o_data_ready;
            i_flush <= 1'b0;
            if (o_data_ready && !rf_prev) begin
                rf_req_count <= rf_req_count + 1;
                if (rf_enable) rf_cnt <= 1;
            end else if (rf_cnt == 4) begin
                rf_cnt  <= 0;
                i_flush <= 1'b1;
            end else if (rf_cnt != 0) begin
                rf_cnt <= rf_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 7) ? 32'h7777_7777 : 32'd0;
            rf_loaded <= 1'b1;
        end else if (!rst && rf_cnt == 4) begin
            rf_mem[o_rd] <= o_write_data;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); end
        checks++; if (o_data_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_data_ready: got %b expected 0", o_data_ready); end
        checks++; if (o_done !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_done_timeout: got %b%b expected 00", o_done, o_timeout); end
        checks++; if (o_rd !== 5'd0 || o_write_data !== 32'd0) begin fails++; $display("[TB] FAIL reset_rd_data: got %0d/%h expected 0/0", o_rd, o_write_data); end
        checks++; if (o_retire_count !== '0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", o_retire_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int k;
        bit found;
        checks++; if (o_ready !== 1'b1) begin fails++; $display("[TB] FAIL write_idle_ready: got %b expected 1", o_ready); end
        i_valid = 1'b1; i_reg_write = 1'b1; i_rd = 5'd5; i_result = 32'hDEAD_BEEF;
        @(negedge clk);
        i_valid = 1'b0; i_rd = 5'd0; i_result = 32'd0;
        checks++; if (o_data_ready !== 1'b1) begin fails++; $display("[TB] FAIL write_req_e1: got %b expected 1", o_data_ready); end
        checks++; if (o_rd !== 5'd5 || o_write_data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL write_latch: got %0d/%h expected 5/deadbeef", o_rd, o_write_data); end
        k = 1; found = 1'b0;
        while (k < 20 && !found) begin
            @(negedge clk);
            k++;
            if (o_done) found = 1'b1;
        end
        checks++; if (!found || k != 8) begin fails++; $display("[TB] FAIL write_done_cycle: got E+%0d (found=%0d) expected E+8", k, found); end
        exp_count = exp_count + 1'b1;
        checks++; if (o_retire_count !== exp_count) begin fails++; $display("[TB] FAIL write_count: got %0d expected %0d", o_retire_count, exp_count); end
        checks++; if (rf_mem[5] !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL write_reg5: got %h expected deadbeef", rf_mem[5]); end
        @(negedge clk);
        checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin fails++; $display("[TB] FAIL write_reaccept_e9: got ready=%b done=%b expected 1/0", o_ready, o_done); end
    endtask

    task automatic test_no_write();
        int req0;
        req0 = rf_req_count;
        i_valid = 1'b1; i_reg_write = 1'b1; i_rd = 5'd0; i_result = 32'h0000_1234;
        @(negedge clk);
        checks++; if (o_done !== 1'b1 || o_data_ready !== 1'b0) begin fails++; $display("[TB] FAIL x0_done_e1: got done=%b req=%b expected 1/0", o_done, o_data_ready); end
        i_reg_write = 1'b0; i_rd = 5'd7; i_result = 32'h5555_AAAA;
        @(negedge clk);
        checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin fails++; $display("[TB] FAIL x0_ready_e2: got ready=%b done=%b expected 1/0", o_ready, o_done); end
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (o_done !== 1'b1 || o_rd !== 5'd7 || o_data_ready !== 1'b0) begin fails++; $display("[TB] FAIL nowrite_done: got done=%b rd=%0d req=%b expected 1/7/0", o_done, o_rd, o_data_ready); end
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin fails++; $display("[TB] FAIL nowrite_ready: got %b expected 1", o_ready); end
        checks++; if (rf_req_count != req0) begin fails++; $display("[TB] FAIL nowrite_no_req: got %0d requests expected %0d", rf_req_count, req0); end
        checks++; if (rf_mem[0] !== 32'd0 || rf_mem[7] !== 32'h7777_7777) begin fails++; $display("[TB] FAIL nowrite_regs: got r0=%h r7=%h expected 0/77777777", rf_mem[0], rf_mem[7]); end
        exp_count = exp_count + 2'd2;
        checks++; if (o_retire_count !== exp_count) begin fails++; $display("[TB] FAIL nowrite_count: got %0d expected %0d", o_retire_count, exp_count); end
    endtask

    task automatic test_timeout();
        int hi;
        int k;
        bit found;
        rf_enable = 1'b0;
        i_valid = 1'b1; i_reg_write = 1'b1; i_rd = 5'd9; i_result = 32'h0BAD_F00D;
        @(negedge clk);
        i_valid = 1'b0;
        hi = 0;
        while (o_data_ready && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        checks++; if (hi != TIMEOUT_CYCLES) begin fails++; $display("[TB] FAIL timeout_req_len: got %0d expected %0d", hi, TIMEOUT_CYCLES); end
        checks++; if (o_timeout !== 1'b1) begin fails++; $display("[TB] FAIL timeout_flag: got %b expected 1", o_timeout); end
        @(negedge clk);
        checks++; if (o_done !== 1'b1) begin fails++; $display("[TB] FAIL timeout_done: got %b expected 1", o_done); end
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin fails++; $display("[TB] FAIL timeout_idle: got %b expected 1", o_ready); end
        exp_count = exp_count + 1'b1;
        checks++; if (rf_mem[9] !== 32'd0) begin fails++; $display("[TB] FAIL timeout_reg9: got %h expected 0", rf_mem[9]); end
        rf_enable = 1'b1;
        i_valid = 1'b1; i_reg_write = 1'b1; i_rd = 5'd10; i_result = 32'h1357_9BDF;
        @(negedge clk);
        i_valid = 1'b0;
        k = 0; found = 1'b0;
        while (k < 20 && !found) begin
            @(negedge clk);
            k++;
            if (o_done) found = 1'b1;
        end
        checks++; if (!found) begin fails++; $display("[TB] FAIL post_timeout_done: got no o_done expected a pulse"); end
        @(negedge clk);
        exp_count = exp_count + 1'b1;
        checks++; if (rf_mem[10] !== 32'h1357_9BDF) begin fails++; $display("[TB] FAIL post_timeout_reg10: got %h expected 13579bdf", rf_mem[10]); end
        checks++; if (o_timeout !== 1'b1) begin fails++; $display("[TB] FAIL timeout_sticky: got %b expected 1", o_timeout); end
        checks++; if (o_retire_count !== exp_count) begin fails++; $display("[TB] FAIL timeout_count: got %0d expected %0d", o_retire_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        int rises;
        int idx;
        int k;
        logic prev;
        bit finished;
        rises = 0; prev = o_data_ready; finished = 1'b0;
        i_valid = 1'b1; i_reg_write = 1'b1; i_rd = 5'd1; i_result = 32'd1;
        idx = 2; k = 0;
        while (k < 80 && !finished) begin
            @(negedge clk);
            k++;
            if (o_data_ready && !prev) rises++;
            prev = o_data_ready;
            if (o_ready) begin
                if (idx <= 3) begin
                    i_rd = 5'(idx); i_result = 32'(idx);
                    idx++;
                end else begin
                    finished = 1'b1;
                end
            end
        end
        i_valid = 1'b0;
        checks++; if (!finished) begin fails++; $display("[TB] FAIL b2b_complete: got %0d cycles without finishing expected completion", k); end
        checks++; if (rises != 3) begin fails++; $display("[TB] FAIL b2b_rises: got %0d expected 3", rises); end
        checks++; if (rf_mem[1] !== 32'd1 || rf_mem[2] !== 32'd2 || rf_mem[3] !== 32'd3) begin fails++; $display("[TB] FAIL b2b_regs: got %h %h %h expected 1 2 3", rf_mem[1], rf_mem[2], rf_mem[3]); end
        exp_count = exp_count + 2'd3;
        checks++; if (o_retire_count !== exp_count) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected %0d", o_retire_count, exp_count); end
    endtask

    task automatic test_reset_mid_req();
        bit seen_done;
        i_valid = 1'b1; i_reg_write = 1'b1; i_rd = 5'd4; i_result = 32'h4444_4444;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_data_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreq_setup: got %b expected 1", o_data_ready); end
        #1 rst = 1'b1;
        #1;
        checks++; if (o_data_ready !== 1'b0 || o_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreq_async: got req=%b ready=%b expected 0/1", o_data_ready, o_ready); end
        checks++; if (o_retire_count !== '0 || o_done !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("[TB] FAIL midreq_clear: got count=%0d done=%b timeout=%b expected 0/0/0", o_retire_count, o_done, o_timeout); end
        checks++; if (o_rd !== 5'd0 || o_write_data !== 32'd0) begin fails++; $display("[TB] FAIL midreq_rd_data: got %0d/%h expected 0/0", o_rd, o_write_data); end
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_done) seen_done = 1'b1;
        end
        checks++; if (seen_done || o_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreq_quiet: got done_seen=%0d ready=%b expected 0/1", seen_done, o_ready); end
        checks++; if (rf_mem[4] !== 32'd0) begin fails++; $display("[TB] FAIL midreq_reg4: got %h expected 0", rf_mem[4]); end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        i_valid = 1'b1; i_reg_write = 1'b0; i_rd = 5'd12; i_result = 32'hCAFE_0000;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (o_done) pulses++;
            if (n == 29) begin
                checks++; if (o_retire_count !== 4'hF) begin fails++; $display("[TB] FAIL wrap_count15: got %0d expected 15", o_retire_count); end
            end
        end
        i_valid = 1'b0;
        checks++; if (pulses != 16) begin fails++; $display("[TB] FAIL wrap_pulses: got %0d expected 16", pulses); end
        checks++; if (o_retire_count !== 4'h0) begin fails++; $display("[TB] FAIL wrap_count0: got %0d expected 0", o_retire_count); end
        @(negedge clk);
        checks++; if (o_ready !== 1'b1 || rf_mem[12] !== 32'd0) begin fails++; $display("[TB] FAIL wrap_idle: got ready=%b r12=%h expected 1/0", o_ready, rf_mem[12]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
